// File: rtl/round_referee_pkg.sv
// rtl/round_referee_pkg.sv - shared types, constants and helpers for the reaction-game referee
package round_referee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_GO   = 3'd2,
        ST_WIN1 = 3'd3,
        ST_WIN2 = 3'd4
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Taps 8,6,5,4 expressed as bit positions 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Fibonacci step: shift left, feed parity of tapped bits into bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] value);
        return {value[6:0], ^(value & LFSR_TAPS)};
    endfunction

    // Bits needed to hold 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/round_referee_btn_sync_edge.sv
// rtl/round_referee_btn_sync_edge.sv - button synchroniser with rising-edge press detect
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic press_out
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Shift the raw button through the synchroniser and remember the last settled level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // A held button yields exactly one press: only the low-to-high transition counts
    assign press_out = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/round_referee.sv
// rtl/round_referee.sv - reaction-game referee: round sequencing and winner levels
module round_referee
    import round_referee_pkg::*;
#(
    parameter int CLOCK_FREQ       = 12000000,
    parameter int TICK_COUNT       = CLOCK_FREQ / 100,
    parameter int MIN_DELAY_TICKS  = 50,
    parameter int GO_TIMEOUT_TICKS = 300,
    parameter int SYNC_STAGES      = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start_in,
    input  logic btn1_in,
    input  logic btn2_in,
    input  logic w_done_in,
    output logic go_led_out,
    output logic w1_out,
    output logic w2_out,
    output logic false_start_out,
    output logic tie_out,
    output logic busy_out
);

    localparam int PW = cnt_width(TICK_COUNT - 1);
    localparam int DW = cnt_width(MIN_DELAY_TICKS + 15);
    localparam int GW = cnt_width(GO_TIMEOUT_TICKS);

    state_t          r_state;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_lfsr;
    logic [DW-1:0]   r_delay;
    logic [GW-1:0]   r_go_cnt;
    logic            r_go_led;
    logic            r_w1;
    logic            r_w2;
    logic            r_false_start;
    logic            r_tie;
    logic            r_busy;
    logic            w_tick;
    logic            w_press1;
    logic            w_press2;

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn1_in),
        .press_out (w_press1)
    );

    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync2 (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn2_in),
        .press_out (w_press2)
    );

    assign w_tick = (r_presc == PW'(TICK_COUNT - 1));

    // Free-running prescaler; the tick is the clock in which it wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Random source advances every clock so the wait length depends on when start arrives
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    // Round FSM; presses are checked before counter expiry so a press always wins the race
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_delay       <= '0;
            r_go_cnt      <= '0;
            r_go_led      <= 1'b0;
            r_w1          <= 1'b0;
            r_w2          <= 1'b0;
            r_false_start <= 1'b0;
            r_tie         <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_false_start <= 1'b0;
            r_tie         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_state <= ST_WAIT;
                        r_delay <= DW'(MIN_DELAY_TICKS) + DW'(r_lfsr[3:0]);
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_press1 && w_press2) begin
                        r_state       <= ST_IDLE;
                        r_false_start <= 1'b1;
                        r_tie         <= 1'b1;
                        r_busy        <= 1'b0;
                    end else if (w_press1) begin
                        r_state       <= ST_WIN2;
                        r_w2          <= 1'b1;
                        r_false_start <= 1'b1;
                    end else if (w_press2) begin
                        r_state       <= ST_WIN1;
                        r_w1          <= 1'b1;
                        r_false_start <= 1'b1;
                    end else if (r_delay == '0) begin
                        r_state  <= ST_GO;
                        r_go_cnt <= GW'(GO_TIMEOUT_TICKS);
                        r_go_led <= 1'b1;
                    end else if (w_tick) begin
                        r_delay <= r_delay - DW'(1);
                    end
                end
                ST_GO: begin
                    if (w_press1 && w_press2) begin
                        r_state  <= ST_IDLE;
                        r_tie    <= 1'b1;
                        r_go_led <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_press1) begin
                        r_state  <= ST_WIN1;
                        r_w1     <= 1'b1;
                        r_go_led <= 1'b0;
                    end else if (w_press2) begin
                        r_state  <= ST_WIN2;
                        r_w2     <= 1'b1;
                        r_go_led <= 1'b0;
                    end else if (r_go_cnt == '0) begin
                        r_state  <= ST_IDLE;
                        r_go_led <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_tick) begin
                        r_go_cnt <= r_go_cnt - GW'(1);
                    end
                end
                ST_WIN1, ST_WIN2: begin
                    if (w_done_in) begin
                        r_state <= ST_IDLE;
                        r_w1    <= 1'b0;
                        r_w2    <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_go_led <= 1'b0;
                    r_w1     <= 1'b0;
                    r_w2     <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign go_led_out      = r_go_led;
    assign w1_out          = r_w1;
    assign w2_out          = r_w2;
    assign false_start_out = r_false_start;
    assign tie_out         = r_tie;
    assign busy_out        = r_busy;

endmodule
